uart_apb_sequencer: RTL and testbench



---
 rtl/uart_apb_sequencer.sv | 182 ++++++++++++++++++
 tb/tb_uart_apb_sequencer.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_apb_sequencer.sv
// rtl/uart_apb_sequencer.sv - APB3 master that configures, polls and services a CoreUARTapb instance
// Ports:
//   PCLK, PRESET                clock, asynchronous active-high reset
//   PSEL, PENABLE, PWRITE,
//   PADDR, PWDATA               APB request towards the UART
//   PRDATA, PREADY, PSLVERR     APB response from the UART
//   tx_data, tx_valid, tx_ready byte stream into the UART transmitter
//   rx_data, rx_valid, rx_ready byte stream out of the UART receiver
//   cfg_done                    baud and mode registers have been written
//   err_flags, err_clr          sticky {bus_timeout, pslverr, framing, overflow, parity} and clear
module uart_apb_sequencer #(
  parameter logic [12:0] BAUD_VALUE     = 13'd1,
  parameter bit          BIT8           = 1'b1,
  parameter bit          PARITY_EN      = 1'b0,
  parameter bit          ODD_N_EVEN     = 1'b0,
  parameter int          TIMEOUT_CYCLES = 15
) (
  input  logic       PCLK,
  input  logic       PRESET,
  output logic       PSEL,
  output logic       PENABLE,
  output logic       PWRITE,
  output logic [4:0] PADDR,
  output logic [7:0] PWDATA,
  input  logic [7:0] PRDATA,
  input  logic       PREADY,
  input  logic       PSLVERR,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       cfg_done,
  output logic [4:0] err_flags,
  input  logic       err_clr
);

  typedef enum logic [2:0] {S_CFG1, S_CFG2, S_STAT, S_DECIDE, S_RXRD, S_TXWR} state_t;
  typedef enum logic [1:0] {PH_IDLE, PH_SETUP, PH_ACCESS} phase_t;

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t     state_q, state_d, setup_state;
  phase_t     phase_q, phase_d;
  logic [7:0] tmo_q;
  logic [1:0] status_q;            // {RXRDY, TXRDY} from the last STATUS read
  logic       go_setup, xfer_ok, xfer_abort;
  logic [4:0] addr_d;
  logic       wr_d;
  logic [7:0] wd_d;
  logic [4:0] err_set;

  // PH_IDLE of a transfer state is the bus-idle cycle before its SETUP.
  // DECIDE is itself a bus-idle cycle, so it launches the chosen SETUP directly.
  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    setup_state = state_q;
    go_setup    = 1'b0;
    xfer_ok     = 1'b0;
    xfer_abort  = 1'b0;
    PSEL        = 1'b0;
    PENABLE     = 1'b0;
    tx_ready    = 1'b0;
    addr_d      = 5'h10;
    wr_d        = 1'b0;
    wd_d        = 8'h00;

    case (phase_q)
      PH_IDLE: begin
        if (state_q == S_DECIDE) begin
          if (status_q[1] && !rx_valid)
            setup_state = S_RXRD;
          else if (status_q[0] && tx_valid)
            setup_state = S_TXWR;
          else
            setup_state = S_STAT;
        end
        state_d  = setup_state;
        phase_d  = PH_SETUP;
        go_setup = 1'b1;
      end
      PH_SETUP: begin
        PSEL    = 1'b1;
        phase_d = PH_ACCESS;
      end
      default: begin
        PSEL    = 1'b1;
        PENABLE = 1'b1;
        if (PREADY)
          xfer_ok = 1'b1;
        else if (tmo_q == TMO_LAST)
          xfer_abort = 1'b1;
        tx_ready = PREADY && (state_q == S_TXWR);
        if (xfer_ok || xfer_abort) begin
          phase_d = PH_IDLE;
          case (state_q)
            S_CFG1:  state_d = S_CFG2;
            S_STAT:  state_d = S_DECIDE;
            default: state_d = S_STAT;
          endcase
        end
      end
    endcase

    case (setup_state)
      S_CFG1: begin
        addr_d = 5'h08;
        wr_d   = 1'b1;
        wd_d   = BAUD_VALUE[7:0];
      end
      S_CFG2: begin
        addr_d = 5'h0C;
        wr_d   = 1'b1;
        wd_d   = {BAUD_VALUE[12:8], ODD_N_EVEN, PARITY_EN, BIT8};
      end
      S_RXRD: addr_d = 5'h04;
      S_TXWR: begin
        addr_d = 5'h00;
        wr_d   = 1'b1;
        wd_d   = tx_data;
      end
      default: addr_d = 5'h10;
    endcase

    err_set    = 5'b00000;
    err_set[4] = xfer_abort;
    err_set[3] = xfer_ok && PSLVERR;
    if (xfer_ok && state_q == S_STAT)
      err_set[2:0] = PRDATA[4:2];
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q   <= S_CFG1;
      phase_q   <= PH_IDLE;
      tmo_q     <= 8'd0;
      status_q  <= 2'b00;
      PADDR     <= 5'h00;
      PWRITE    <= 1'b0;
      PWDATA    <= 8'h00;
      rx_data   <= 8'h00;
      rx_valid  <= 1'b0;
      cfg_done  <= 1'b0;
      err_flags <= 5'b00000;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      // Counts consecutive ACCESS cycles; any other phase restarts it.
      tmo_q   <= (phase_q == PH_ACCESS) ? tmo_q + 8'd1 : 8'd0;

      if (go_setup) begin
        PADDR  <= addr_d;
        PWRITE <= wr_d;
        PWDATA <= wd_d;
      end

      // A timed-out poll must not leave stale ready bits for DECIDE.
      if (state_q == S_STAT && xfer_ok)
        status_q <= PRDATA[1:0];
      else if (state_q == S_STAT && xfer_abort)
        status_q <= 2'b00;

      if (state_q == S_RXRD && xfer_ok) begin
        rx_data  <= PRDATA;
        rx_valid <= 1'b1;
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end

      if (state_q == S_CFG2 && (xfer_ok || xfer_abort))
        cfg_done <= 1'b1;

      if (err_clr)
        err_flags <= 5'b00000;
      else
        err_flags <= err_flags | err_set;
    end
  end

endmodule

// File: tb/tb_uart_apb_sequencer.sv
// tb/tb_uart_apb_sequencer.sv - scoreboard bench for uart_apb_sequencer with a behavioural UART slave
module tb_uart_apb_sequencer;

  logic       PCLK = 1'b0;
  logic       PRESET;
  logic       PSEL, PENABLE, PWRITE;
  logic [4:0] PADDR;
  logic [7:0] PWDATA, PRDATA;
  logic       PREADY, PSLVERR;
  logic [7:0] tx_data;
  logic       tx_valid, tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid, rx_ready;
  logic       cfg_done;
  logic [4:0] err_flags;
  logic       err_clr;

  // UART slave model controls
  logic [2:0] st_err;
  logic       txrdy;
  logic       stall_en;
  logic [4:0] stall_addr;
  logic       slverr_en;
  logic [7:0] rx_mem [16];
  int         rx_reads_allowed;
  int         rx_reads_seen = 0;
  logic       rxrdy;

  // scoreboard
  logic [13:0] apb_exp [$];
  logic [7:0]  rx_exp [$];
  logic [7:0]  tx_exp [$];
  logic [13:0] setup_vec = 14'h0;
  int          n_cmp = 0;
  int          n_err = 0;

  always #5 PCLK = ~PCLK;

  uart_apb_sequencer #(
    .BAUD_VALUE(13'h155), .BIT8(1'b1), .PARITY_EN(1'b1), .ODD_N_EVEN(1'b0), .TIMEOUT_CYCLES(4)
  ) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .cfg_done(cfg_done), .err_flags(err_flags), .err_clr(err_clr)
  );

  // RXRDY stays up while bytes remain that the sequencer has not yet started reading.
  assign rxrdy   = (rx_reads_allowed > rx_reads_seen);
  assign PREADY  = PSEL && PENABLE && !(stall_en && PADDR == stall_addr);
  assign PSLVERR = PSEL && PENABLE && slverr_en;

  always_comb begin
    PRDATA = 8'h00;
    if (PADDR == 5'h10)
      PRDATA = {3'b000, st_err, rxrdy, txrdy};
    else if (PADDR == 5'h04)
      PRDATA = rx_mem[(rx_reads_seen + 15) % 16];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name, input logic [31:0] act);
    n_cmp++;
    n_err++;
    $display("FAIL %s: got 0x%0h required nothing", name, act);
  endtask

  // Monitor: compares every non-poll APB transfer, every tx accept and every rx handshake.
  always @(negedge PCLK) begin
    if (!PRESET) begin
      if (PSEL && !PENABLE) begin
        setup_vec = {PADDR, PWRITE, PWDATA};
        if (PADDR == 5'h04 && !PWRITE)
          rx_reads_seen++;
        if (!(PADDR == 5'h10 && !PWRITE)) begin
          if (apb_exp.size() == 0)
            unexpected("apb_xfer", 32'({PADDR, PWRITE, PWDATA}));
          else
            check("apb_xfer", 32'({PADDR, PWRITE, PWDATA}), 32'(apb_exp.pop_front()));
        end
      end else if (PSEL && PENABLE) begin
        check("apb_hold", 32'({PADDR, PWRITE, PWDATA}), 32'(setup_vec));
      end
      if (tx_ready) begin
        if (tx_exp.size() == 0)
          unexpected("tx_accept", 32'(tx_data));
        else
          check("tx_accept", 32'({PENABLE, PREADY, PADDR, PWRITE, tx_data}),
                32'({1'b1, 1'b1, 5'h00, 1'b1, tx_exp.pop_front()}));
      end
      if (rx_valid && rx_ready) begin
        if (rx_exp.size() == 0)
          unexpected("rx_byte", 32'(rx_data));
        else
          check("rx_byte", 32'(rx_data), 32'(rx_exp.pop_front()));
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge PCLK);
    #1;
  endtask

  task automatic wait_setup(input logic [4:0] a, input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge PCLK);
      if (PSEL && !PENABLE && PADDR == a) ok = 1'b1;
    end
    check(name, 32'(ok), 32'd1);
  endtask

  task automatic wait_rx_valid(input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge PCLK);
      if (rx_valid) ok = 1'b1;
    end
    check(name, 32'(ok), 32'd1);
  endtask

  task automatic wait_tx_accept(input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge PCLK);
      if (tx_ready) ok = 1'b1;
    end
    check(name, 32'(ok), 32'd1);
    @(posedge PCLK);
    #1 tx_valid = 1'b0;
  endtask

  task automatic push_cfg();
    apb_exp.push_back({5'h08, 1'b1, 8'h55});
    apb_exp.push_back({5'h0C, 1'b1, 8'h0B});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int acc;
    bit seen;
    PRESET = 1'b1; tx_valid = 1'b0; tx_data = 8'h00; rx_ready = 1'b0; err_clr = 1'b0;
    st_err = 3'b000; txrdy = 1'b0; stall_en = 1'b0; stall_addr = 5'h00; slverr_en = 1'b0;
    rx_reads_allowed = 0;
    for (int i = 0; i < 16; i++) rx_mem[i] = 8'h00;

    // reset state
    #12;
    check("reset_outputs", 32'({PSEL, PENABLE, PWRITE, PADDR, PWDATA, tx_ready, rx_data,
                                rx_valid, cfg_done, err_flags}), 32'd0);

    // configuration sequence
    push_cfg();
    @(negedge PCLK);
    PRESET = 1'b0;
    wait_setup(5'h0C, "wait_cfg2");
    @(negedge PCLK);
    check("cfg_done_during_cfg2", 32'(cfg_done), 32'd0);
    @(negedge PCLK);
    check("cfg_done_after_cfg2", 32'({cfg_done, PSEL}), 32'({1'b1, 1'b0}));
    @(negedge PCLK);
    check("first_poll", 32'({PSEL, PENABLE, PWRITE, PADDR}), 32'({1'b1, 1'b0, 1'b0, 5'h10}));

    // receive two bytes, consumer stalls on the first
    cycles(1);
    rx_mem[0] = 8'hA5; rx_mem[1] = 8'hC3;
    apb_exp.push_back({5'h04, 1'b0, 8'h00});
    apb_exp.push_back({5'h04, 1'b0, 8'h00});
    rx_exp.push_back(8'hA5); rx_exp.push_back(8'hC3);
    rx_reads_allowed = 2;
    wait_rx_valid("wait_rx_a5");
    check("rx_data_a5", 32'(rx_data), 32'hA5);
    cycles(40);
    check("rx_held_no_reread", 32'({rx_valid, rxrdy, 8'(rx_reads_seen)}), 32'({1'b1, 1'b1, 8'd1}));
    rx_ready = 1'b1;
    cycles(1);
    rx_ready = 1'b0;
    wait_rx_valid("wait_rx_c3");
    check("rx_data_c3", 32'(rx_data), 32'hC3);
    cycles(1);
    rx_ready = 1'b1;
    cycles(1);
    rx_ready = 1'b0;
    cycles(10);
    check("rx_valid_cleared", 32'(rx_valid), 32'd0);

    // transmit one byte
    apb_exp.push_back({5'h00, 1'b1, 8'h3C});
    tx_exp.push_back(8'h3C);
    txrdy = 1'b1; tx_data = 8'h3C; tx_valid = 1'b1;
    wait_tx_accept("wait_tx_3c");
    cycles(20);

    // RX and TX both pending: RX read must come first
    rx_ready = 1'b1;
    rx_mem[2] = 8'h3D;
    apb_exp.push_back({5'h04, 1'b0, 8'h00});
    apb_exp.push_back({5'h00, 1'b1, 8'h5A});
    rx_exp.push_back(8'h3D);
    tx_exp.push_back(8'h5A);
    wait_setup(5'h10, "wait_poll_both");
    rx_reads_allowed = 3; tx_data = 8'h5A; tx_valid = 1'b1;
    wait_tx_accept("wait_tx_5a");
    cycles(20);
    rx_ready = 1'b0;
    txrdy = 1'b0;
    check("rx_then_tx_done", 32'(rx_reads_seen), 32'd3);

    // UART status errors, clear, slave error
    st_err = 3'b111;
    cycles(12);
    check("err_status_bits", 32'(err_flags), 32'b00111);
    st_err = 3'b000;
    cycles(8);
    err_clr = 1'b1;
    cycles(1);
    err_clr = 1'b0;
    @(negedge PCLK);
    check("err_cleared", 32'(err_flags), 32'd0);
    cycles(1);
    slverr_en = 1'b1;
    cycles(8);
    slverr_en = 1'b0;
    cycles(2);
    check("err_pslverr", 32'(err_flags), 32'b01000);
    err_clr = 1'b1;
    cycles(1);
    err_clr = 1'b0;
    cycles(1);
    check("err_cleared_2", 32'(err_flags), 32'd0);

    // write that never gets PREADY: abort after four ACCESS cycles
    stall_en = 1'b1; stall_addr = 5'h00;
    apb_exp.push_back({5'h00, 1'b1, 8'h77});
    txrdy = 1'b1; tx_data = 8'h77; tx_valid = 1'b1;
    wait_setup(5'h00, "wait_stalled_tx");
    tx_valid = 1'b0; txrdy = 1'b0;
    acc = 0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge PCLK);
      if (PSEL && PENABLE) acc++;
      else seen = 1'b1;
    end
    check("timeout_access_cycles", 32'(acc), 32'd4);
    check("timeout_flags", 32'({err_flags, rx_valid, PSEL}), 32'({5'b10000, 1'b0, 1'b0}));
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge PCLK);
      if (PSEL) seen = 1'b1;
    end
    check("timeout_next_setup", 32'({seen, PENABLE, PWRITE, PADDR}), 32'({1'b1, 1'b0, 1'b0, 5'h10}));
    cycles(10);

    // reset in the middle of a TX write
    apb_exp.push_back({5'h00, 1'b1, 8'h99});
    txrdy = 1'b1; tx_data = 8'h99; tx_valid = 1'b1;
    wait_setup(5'h00, "wait_tx_before_reset");
    @(negedge PCLK);
    #2 PRESET = 1'b1;
    #1;
    check("reset_mid_xfer", 32'({PSEL, PENABLE, cfg_done, err_flags, tx_ready, rx_valid}), 32'd0);
    tx_valid = 1'b0; txrdy = 1'b0; stall_en = 1'b0;
    push_cfg();
    @(negedge PCLK);
    PRESET = 1'b0;
    wait_setup(5'h08, "wait_cfg1_again");
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge PCLK);
      if (cfg_done) seen = 1'b1;
    end
    check("cfg_done_again", 32'(seen), 32'd1);
    cycles(20);

    check("apb_queue_empty", 32'(apb_exp.size()), 32'd0);
    check("rx_queue_empty", 32'(rx_exp.size()), 32'd0);
    check("tx_queue_empty", 32'(tx_exp.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
